fmul_iter: RTL and testbench

- Parameterised, iterative IEEE-754 binary floating-point multiplier with valid/ready handshakes on both sides.
- Successor to the combinational single-precision multiplier. Adds:
  - generic exponent/mantissa widths;
  - shift-add datapath (one partial product per cycle) instead of a full-width array multiplier;
  - four rounding modes;
  - full exception flags.
- Sits between the FPU issue stage and the result writeback arbiter. One operation is in flight at a time.

---
 rtl/fmul_iter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fmul_iter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fmul_iter.sv
// Iterative IEEE-754 multiplier: shift-add significand product, then normalise and
// round in one cycle each; specials are classified at accept and ride the same latency.
module fmul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [1:0]           in_rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic [4:0]           out_flags
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(SW);
  localparam int LW = $clog2(PW) + 1;

  localparam logic signed [EW-1:0] BIAS     = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_TOP  = EW'((2 ** EXP_W) - 1);
  localparam logic        [CW-1:0] CNT_LAST = CW'(MAN_W);
  localparam logic        [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

  typedef struct packed {
    logic zero;
    logic den;
    logic inf;
    logic nan;
    logic snan;
  } cls_t;

  function automatic cls_t classify(input logic [W-2:0] x);
    cls_t c;
    logic exp_ones, exp_zero, frac_zero;
    exp_ones  = &x[W-2:MAN_W];
    exp_zero  = ~|x[W-2:MAN_W];
    frac_zero = ~|x[MAN_W-1:0];
    c.zero    = exp_zero & frac_zero;
    c.den     = exp_zero & ~frac_zero;
    c.inf     = exp_ones & frac_zero;
    c.nan     = exp_ones & ~frac_zero;
    c.snan    = c.nan & ~x[MAN_W-1];
    return c;
  endfunction

  state_t state, state_nx;

  logic               sa, sb;
  logic [EXP_W-1:0]   ea_r, eb_r;
  logic [1:0]         rm_r;
  cls_t               cls_a, cls_b;
  logic [PW-1:0]      mcand, acc;
  logic [SW-1:0]      mplier;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      nm;
  logic signed [EW-1:0] ne;
  logic               nst;

  // normalise stage signals
  logic signed [EW-1:0] ea_eff, eb_eff, e0, lim, lz_s, shl, rsh, n_e;
  logic [LW-1:0]      lz;
  logic               found;
  logic [PW-1:0]      n_m;
  logic               n_st;

  // round stage signals
  logic               sgn, g, r, s, inc, inexact, tiny, ovf, to_inf;
  logic [SW:0]        sum;
  logic [MAN_W-1:0]   frac;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]       r_data;
  logic [4:0]         r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MUL;
      end
      MUL:     if (cnt == CNT_LAST) state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= 1'b0;
      sb        <= 1'b0;
      ea_r      <= '0;
      eb_r      <= '0;
      rm_r      <= '0;
      cls_a     <= '0;
      cls_b     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      nm        <= '0;
      ne        <= '0;
      nst       <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa     <= in_a[W-1];
          sb     <= in_b[W-1];
          ea_r   <= in_a[W-2:MAN_W];
          eb_r   <= in_b[W-2:MAN_W];
          rm_r   <= in_rm;
          cls_a  <= classify(in_a[W-2:0]);
          cls_b  <= classify(in_b[W-2:0]);
          mcand  <= PW'({|in_a[W-2:MAN_W], in_a[MAN_W-1:0]});
          mplier <= {|in_b[W-2:MAN_W], in_b[MAN_W-1:0]};
          acc    <= '0;
          cnt    <= '0;
        end
        MUL: begin
          // multiplicand register tracks (sig_a << cnt)
          if (mplier[cnt]) acc <= acc + mcand;
          mcand <= mcand << 1;
          cnt   <= cnt + CW'(1);
        end
        NORM: begin
          nm  <= n_m;
          ne  <= n_e;
          nst <= n_st;
        end
        ROUND: begin
          out_data  <= r_data;
          out_flags <= r_flags;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ea_eff = cls_a.den ? EW'(1) : EW'(ea_r);
    eb_eff = cls_b.den ? EW'(1) : EW'(eb_r);
    e0     = ea_eff + eb_eff - BIAS;

    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PW - 1; i++) begin
      if (!found) begin
        if (acc[PW-2-i]) found = 1'b1;
        else             lz    = lz + LW'(1);
      end
    end
    lz_s = EW'(lz);
    lim  = e0 - EW'(1);
    shl  = '0;
    rsh  = '0;
    n_m  = acc;
    n_e  = e0;
    n_st = 1'b0;

    if (acc[PW-1]) begin
      n_m  = acc >> 1;
      n_st = acc[0];
      n_e  = e0 + EW'(1);
    end else if (lim > 0) begin
      shl = (lim > lz_s) ? lz_s : lim;
      n_m = acc << shl;
      n_e = e0 - shl;
    end

    // Exponent 0 marks a denormal significand (hidden bit clear, scale of exponent 1).
    if (n_e < 1) begin
      rsh = EW'(1) - n_e;
      if (rsh >= PW) begin
        n_st = n_st | (|n_m);
        n_m  = '0;
      end else begin
        n_st = n_st | (|(n_m << (PW - rsh)));
        n_m  = n_m >> rsh;
      end
      n_e = '0;
    end else if (n_e == 1 && !n_m[PW-2]) begin
      n_e = '0;
    end
  end

  always_comb begin
    sgn     = sa ^ sb;
    g       = nm[MAN_W-1];
    r       = nm[MAN_W-2];
    s       = (|nm[MAN_W-3:0]) | nst;
    inexact = g | r | s;
    tiny    = (ne == 0);

    case (rm_r)
      2'b00:   inc = g & (r | s | nm[MAN_W]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = inexact & ~sgn;
      default: inc = inexact & sgn;
    endcase

    case (rm_r)
      2'b00:   to_inf = 1'b1;
      2'b01:   to_inf = 1'b0;
      2'b10:   to_inf = ~sgn;
      default: to_inf = sgn;
    endcase

    sum = nm[PW-1:MAN_W] + {{SW{1'b0}}, inc};
    if (sum[SW]) begin
      frac = sum[MAN_W:1];
      e_r  = ne + EW'(1);
    end else begin
      frac = sum[MAN_W-1:0];
      e_r  = (ne == 0 && sum[MAN_W]) ? EW'(1) : ne;
    end
    ovf = (e_r >= EXP_TOP);

    r_data  = {sgn, e_r[EXP_W-1:0], frac};
    r_flags = {3'b000, tiny & inexact, inexact};
    if (ovf) begin
      r_data  = to_inf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      r_flags = 5'b00101;
    end

    if (cls_a.nan | cls_b.nan | (cls_a.inf & cls_b.zero) | (cls_a.zero & cls_b.inf)) begin
      r_data  = QNAN;
      r_flags = {cls_a.snan | cls_b.snan | (cls_a.inf & cls_b.zero) | (cls_a.zero & cls_b.inf),
                 4'b0000};
    end else if (cls_a.inf | cls_b.inf) begin
      r_data  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_flags = '0;
    end else if (cls_a.zero | cls_b.zero) begin
      r_data  = {sgn, {(W-1){1'b0}}};
      r_flags = '0;
    end
  end

endmodule

// File: tb/tb_fmul_iter.sv
// Directed bench for fmul_iter: expected results are queued at issue and compared
// at the output handshake, together with latency, hold and reset-abort checks.
module tb_fmul_iter;

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;
  localparam int         LAT = 26;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_flags;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fmul_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [31:0] ed, input logic [4:0] ef,
                        input int hold);
    exp_t        e;
    int          n;
    logic        got;
    logic [31:0] d0;
    logic [4:0]  f0;
    sb.push_back({ed, ef});
    @(negedge clk);
    chk($sformatf("%s.idle_ready", tag), in_ready, 1'b1);
    in_a     = a;
    in_b     = b;
    in_rm    = rm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("%s.busy", tag), in_ready, 1'b0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      got = out_valid;
    end
    chk($sformatf("%s.latency", tag), n, LAT);
    e = sb.pop_front();
    if (got) begin
      d0 = out_data;
      f0 = out_flags;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk($sformatf("%s.hold_valid", tag), out_valid, 1'b1);
        chk($sformatf("%s.hold_data", tag), out_data, d0);
        chk($sformatf("%s.hold_flags", tag), out_flags, f0);
        chk($sformatf("%s.hold_ready", tag), in_ready, 1'b0);
      end
      chk($sformatf("%s.data", tag), out_data, e.d);
      chk($sformatf("%s.flags", tag), out_flags, e.f);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk($sformatf("%s.post_valid", tag), out_valid, 1'b0);
      chk($sformatf("%s.post_ready", tag), in_ready, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_rm     = RNE;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset.in_ready", in_ready, 1'b1);
    chk("reset.out_valid", out_valid, 1'b0);
    chk("reset.out_data", out_data, 32'h0);
    chk("reset.out_flags", out_flags, 5'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_3x2p5",   32'h40400000, 32'h40200000, RNE, 32'h40F00000, 5'b00000, 5);
    run_op("mul_1p5sq",   32'h3FC00000, 32'h3FC00000, RNE, 32'h40100000, 5'b00000, 0);
    run_op("inf_x_zero",  32'h7F800000, 32'h00000000, RNE, 32'h7FC00000, 5'b10000, 0);
    run_op("ninf_x_2",    32'hFF800000, 32'h40000000, RNE, 32'hFF800000, 5'b00000, 1);
    run_op("snan_x_1",    32'h7FA00000, 32'h3F800000, RNE, 32'h7FC00000, 5'b10000, 0);
    run_op("qnan_x_2",    32'h7FC00000, 32'h40000000, RNE, 32'h7FC00000, 5'b00000, 0);
    run_op("nzero_x_3",   32'h80000000, 32'h40400000, RNE, 32'h80000000, 5'b00000, 0);
    run_op("ovf_rne",     32'h7F7FFFFF, 32'h40000000, RNE, 32'h7F800000, 5'b00101, 0);
    run_op("ovf_rtz",     32'h7F7FFFFF, 32'h40000000, RTZ, 32'h7F7FFFFF, 5'b00101, 0);
    run_op("ovf_rdn",     32'h7F7FFFFF, 32'h40000000, RDN, 32'h7F7FFFFF, 5'b00101, 0);
    run_op("ovf_neg_rup", 32'hFF7FFFFF, 32'h40000000, RUP, 32'hFF7FFFFF, 5'b00101, 0);
    run_op("den_exact",   32'h00800000, 32'h3F000000, RNE, 32'h00400000, 5'b00000, 0);
    run_op("den_tie_rne", 32'h00000001, 32'h3F000000, RNE, 32'h00000000, 5'b00011, 0);
    run_op("den_rup",     32'h00000001, 32'h3F000000, RUP, 32'h00000001, 5'b00011, 0);
    run_op("den_tie_odd", 32'h00000003, 32'h3F000000, RNE, 32'h00000002, 5'b00011, 0);
    run_op("den_neg_rdn", 32'h80000001, 32'h3F000000, RDN, 32'h80000001, 5'b00011, 0);
    run_op("den_lshift",  32'h00400000, 32'h4B000000, RNE, 32'h0B800000, 5'b00000, 0);
    run_op("rnd_rne",     32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, 5'b00001, 0);
    run_op("rnd_rtz",     32'h3F800001, 32'h3F800001, RTZ, 32'h3F800002, 5'b00001, 0);
    run_op("rnd_rup",     32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, 5'b00001, 0);
    run_op("den_to_norm", 32'h007FFFFF, 32'h3F800001, RNE, 32'h00800000, 5'b00011, 0);

    @(negedge clk);
    chk("abort.idle_ready", in_ready, 1'b1);
    in_a     = 32'h40400000;
    in_b     = 32'h40200000;
    in_rm    = RNE;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", out_valid, 1'b0);
    chk("abort.in_ready", in_ready, 1'b1);
    chk("abort.out_data", out_data, 32'h0);
    chk("abort.out_flags", out_flags, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort.no_result", out_valid, 1'b0);

    run_op("after_reset", 32'h40400000, 32'h40200000, RNE, 32'h40F00000, 5'b00000, 0);
    run_op("after_rup",   32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, 5'b00001, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
